mem_read_arbiter: RTL and testbench
===================================

# mem_read_arbiter

Two-requester arbiter that shares the single main-memory read-bus port between the instruction-cache and data-cache refill engines. It latches each requester's one-cycle read request, issues the requests one at a time to memory, and routes the 128-bit block response back to the requester that owns it. It sits between the L1 caches and the memory/bridge read interface (dev_rrdy / cpu_ren / cpu_raddr / dev_rvalid / dev_rdata protocol on both sides).

## Interface
- CACHE_BLK_SIZE, 128, width of a refill block on all rdata buses
- cpu_clk  in  1  clock
- cpu_rstn  in  1  reset, asynchronous, active-low
- ic_rrdy  out  1  ICache port may issue a request this cycle
- ic_ren  in  4  ICache read enable (nonzero = request, one-cycle pulse)
- ic_raddr  in  32  ICache block-aligned read address
- ic_rvalid  out  1  one-cycle pulse: ic_rdata holds the ICache block
- ic_rdata  out  CACHE_BLK_SIZE  block returned to ICache
- dc_rrdy, dc_ren, dc_raddr, dc_rvalid, dc_rdata  same as ic_* for the DCache port
- mem_rrdy  in  1  memory can accept a read request
- mem_ren  out  4  read enable to memory
- mem_raddr  out  32  read address to memory
- mem_rvalid  in  1  memory response valid (one-cycle pulse)
- mem_rdata  in  CACHE_BLK_SIZE  memory response block

## Operation
- Per port, one request slot: valid bit, 4-bit ren, 32-bit addr. x_rrdy = !slot_valid (combinational); slot stays valid from capture until its response is delivered.
- Capture: x_ren != 0 while x_rrdy = 1 -> slot loaded at that edge. x_ren != 0 while x_rrdy = 0 is ignored (no state change).
- FSM states: IDLE, WAIT.
  - IDLE: if mem_rrdy and at least one slot valid: select winner, register gnt <= winner, mem_ren <= slot.ren, mem_raddr <= slot.addr, state <= WAIT. Otherwise mem_ren <= 0, mem_raddr <= 0, stay IDLE.
  - WAIT: mem_ren <= 0, mem_raddr <= 0. On mem_rvalid: x_rvalid <= 1 and x_rdata <= mem_rdata for port gnt, clear that slot, last_gnt <= gnt, state <= IDLE.
- Arbitration: one slot valid -> that port. Both valid -> port not equal to last_gnt (round-robin). last_gnt resets to DCache, so first tie goes to ICache.
- mem_rvalid in IDLE is ignored. mem_rvalid in the first WAIT cycle (same cycle mem_ren is visible) is accepted.
- x_rdata holds the last delivered block until the next delivery to that port; meaningful only while x_rvalid = 1.
- Capture into the non-granted port's slot proceeds normally while a transaction is in flight.

## Timing
- Reset values: mem_ren = 0, mem_raddr = 0, ic_rvalid = dc_rvalid = 0, ic_rdata = dc_rdata = 0, slots empty (ic_rrdy = dc_rrdy = 1), state IDLE, last_gnt = DCache.
- Request latency: x_ren at cycle T (mem_rrdy high, other slot empty, IDLE) -> slot valid at T+1 -> mem_ren/mem_raddr driven during T+2 only (exactly one cycle).
- Response latency: mem_rvalid at cycle R -> x_rvalid high during R+1 only; x_rrdy returns to 1 in R+1, so a new x_ren is accepted at R+1.
- Back-to-back: if the other slot is valid, its mem_ren appears in R+2 (IDLE at R+1 grants).
- mem_rrdy low in IDLE: no issue; slots hold; grant happens on first IDLE cycle with mem_rrdy high.
- Reset mid-transaction: all slots, FSM and outputs return to reset values immediately; requesters and memory must be reset together (a stale mem_rvalid after reset arriving in IDLE is dropped).

## Test plan
- Single ICache request: ic_ren=4'hF, ic_raddr=32'h1C00_0010 at T -> mem_ren=4'hF, mem_raddr=32'h1C00_0010 at T+2 only; mem_rvalid with mem_rdata=128'hA5..A5 at R -> ic_rvalid=1, ic_rdata=128'hA5..A5 at R+1, dc_rvalid stays 0.
- Simultaneous ic_ren and dc_ren at T after reset -> ICache issued first (T+2); after its response, DCache issued at R+2; then simultaneous again -> DCache wins only if ICache was last granted (alternation checked over 4 rounds).
- mem_rrdy held low 5 cycles with DCache pending -> mem_ren stays 0; mem_rrdy rises at cycle K -> mem_ren=4'hF at K+1.
- Second dc_ren while dc_rrdy=0 with different address -> ignored; only the first address appears on mem_raddr, one dc_rvalid pulse.
- mem_rvalid asserted in IDLE with no outstanding request -> no x_rvalid, no state change; mem_rvalid in first WAIT cycle -> accepted, delivered next cycle.
- cpu_rstn low during WAIT -> mem_ren=0, both rrdy=1, state IDLE immediately; subsequent request completes normally.

Source files
------------

// File: rtl/mem_read_arbiter_if.sv
// Read-request bus shared by the cache refill ports and the memory port.
// master issues ren/raddr and receives rrdy/rvalid/rdata; slave is the responder.
interface mem_read_arbiter_if #(
    parameter int CACHE_BLK_SIZE = 128
) ();
    logic                      rrdy;
    logic [3:0]                ren;
    logic [31:0]               raddr;
    logic                      rvalid;
    logic [CACHE_BLK_SIZE-1:0] rdata;

    modport master (
        output ren,
        output raddr,
        input  rrdy,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  ren,
        input  raddr,
        output rrdy,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// Shares one memory read port between the ICache (port 0) and DCache (port 1)
// refill engines: one request slot per port, round-robin on ties, one transaction in flight.
module mem_read_arbiter #(
    parameter int CACHE_BLK_SIZE = 128
) (
    input  logic               cpu_clk,
    input  logic               cpu_rstn,
    mem_read_arbiter_if.slave  ic,
    mem_read_arbiter_if.slave  dc,
    mem_read_arbiter_if.master mem
);
    typedef enum logic [0:0] {IDLE, WAIT} state_t;

    state_t state_reg, state_next;
    logic   gnt_reg, gnt_next;
    logic   last_gnt_reg, last_gnt_next;
    logic   winner;

    logic [3:0]  mem_ren_reg, mem_ren_next;
    logic [31:0] mem_raddr_reg, mem_raddr_next;

    logic [3:0]  req_ren  [2];
    logic [31:0] req_addr [2];

    logic                      slot_valid_reg [2];
    logic [3:0]                slot_ren_reg   [2];
    logic [31:0]               slot_addr_reg  [2];
    logic                      rvalid_reg     [2];
    logic [CACHE_BLK_SIZE-1:0] rdata_reg      [2];
    logic [1:0]                deliver;

    assign req_ren[0]  = ic.ren;
    assign req_addr[0] = ic.raddr;
    assign req_ren[1]  = dc.ren;
    assign req_addr[1] = dc.raddr;

    assign ic.rrdy   = !slot_valid_reg[0];
    assign ic.rvalid = rvalid_reg[0];
    assign ic.rdata  = rdata_reg[0];
    assign dc.rrdy   = !slot_valid_reg[1];
    assign dc.rvalid = rvalid_reg[1];
    assign dc.rdata  = rdata_reg[1];

    assign mem.ren   = mem_ren_reg;
    assign mem.raddr = mem_raddr_reg;

    // With both slots pending the port that was not served last wins.
    assign winner = (slot_valid_reg[0] && slot_valid_reg[1]) ? ~last_gnt_reg : slot_valid_reg[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
                if (!cpu_rstn) begin
                    slot_valid_reg[gi] <= 1'b0;
                    slot_ren_reg[gi]   <= '0;
                    slot_addr_reg[gi]  <= '0;
                    rvalid_reg[gi]     <= 1'b0;
                    rdata_reg[gi]      <= '0;
                end else begin
                    rvalid_reg[gi] <= deliver[gi];
                    if (deliver[gi]) begin
                        slot_valid_reg[gi] <= 1'b0;
                        rdata_reg[gi]      <= mem.rdata;
                    end else if (!slot_valid_reg[gi] && req_ren[gi] != 4'd0) begin
                        slot_valid_reg[gi] <= 1'b1;
                        slot_ren_reg[gi]   <= req_ren[gi];
                        slot_addr_reg[gi]  <= req_addr[gi];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_reg     <= IDLE;
            gnt_reg       <= 1'b0;
            last_gnt_reg  <= 1'b1;
            mem_ren_reg   <= '0;
            mem_raddr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            last_gnt_reg  <= last_gnt_next;
            mem_ren_reg   <= mem_ren_next;
            mem_raddr_reg <= mem_raddr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        last_gnt_next  = last_gnt_reg;
        mem_ren_next   = '0;
        mem_raddr_next = '0;
        deliver        = '0;
        case (state_reg)
            IDLE: begin
                if (mem.rrdy && (slot_valid_reg[0] || slot_valid_reg[1])) begin
                    gnt_next       = winner;
                    mem_ren_next   = slot_ren_reg[winner];
                    mem_raddr_next = slot_addr_reg[winner];
                    state_next     = WAIT;
                end
            end
            WAIT: begin
                // A response in the same cycle the request is visible is accepted.
                if (mem.rvalid) begin
                    deliver[gnt_reg] = 1'b1;
                    last_gnt_next    = gnt_reg;
                    state_next       = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scoreboard bench: a transaction-level model predicts memory issues and cache
// deliveries with cycle stamps; a negedge monitor pops and compares them.
module tb_mem_read_arbiter;
    localparam int BLK = 128;

    logic cpu_clk  = 1'b0;
    logic cpu_rstn = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    mem_read_arbiter_if #(.CACHE_BLK_SIZE(BLK)) ic_bus ();
    mem_read_arbiter_if #(.CACHE_BLK_SIZE(BLK)) dc_bus ();
    mem_read_arbiter_if #(.CACHE_BLK_SIZE(BLK)) mem_bus ();

    mem_read_arbiter #(.CACHE_BLK_SIZE(BLK)) dut (
        .cpu_clk  (cpu_clk),
        .cpu_rstn (cpu_rstn),
        .ic       (ic_bus),
        .dc       (dc_bus),
        .mem      (mem_bus)
    );

    typedef struct { int cyc; logic [3:0] ren; logic [31:0] addr; } iss_t;
    typedef struct { int cyc; logic [BLK-1:0] data; } dlv_t;

    iss_t exp_iss[$];
    dlv_t exp_ic[$];
    dlv_t exp_dc[$];

    int pass_cnt  = 0;
    int check_cnt = 0;
    int cyc       = 0;

    // reference model state
    bit          m_busy [2];
    bit          m_pend [2];
    logic [3:0]  m_ren  [2];
    logic [31:0] m_addr [2];
    bit          m_infl;
    int          m_port;
    int          m_issue;
    int          m_last = 1;

    // memory responder state
    bit r_pend, r_hold, r_fixed, spur_en;
    int r_dly, r_dly_max;

    function automatic logic [BLK-1:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[3:0] = 4'd0;
        return a;
    endfunction

    function automatic logic [3:0] rand_ren();
        logic [3:0] r;
        r = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(1, 15));
        return r;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_busy[p] = 0;
            m_pend[p] = 0;
            m_ren[p]  = '0;
            m_addr[p] = '0;
        end
        m_infl = 0;
        m_last = 1;
        exp_iss.delete();
        exp_ic.delete();
        exp_dc.delete();
    endtask

    task automatic model_step(input int c);
        bit          cap [2];
        logic [3:0]  rr  [2];
        logic [31:0] aa  [2];
        int          w;
        iss_t        e;
        dlv_t        d;
        rr[0] = ic_bus.ren;  aa[0] = ic_bus.raddr;
        rr[1] = dc_bus.ren;  aa[1] = dc_bus.raddr;
        for (int p = 0; p < 2; p++) cap[p] = (rr[p] != 4'd0) && !m_busy[p];
        if (m_infl) begin
            if (mem_bus.rvalid && c >= m_issue) begin
                d.cyc  = c + 1;
                d.data = mem_bus.rdata;
                if (m_port == 0) exp_ic.push_back(d);
                else exp_dc.push_back(d);
                m_busy[m_port] = 0;
                m_last = m_port;
                m_infl = 0;
            end
        end else if (mem_bus.rrdy && (m_pend[0] || m_pend[1])) begin
            if (m_pend[0] && m_pend[1]) w = 1 - m_last;
            else w = m_pend[1] ? 1 : 0;
            e.cyc  = c + 1;
            e.ren  = m_ren[w];
            e.addr = m_addr[w];
            exp_iss.push_back(e);
            m_pend[w] = 0;
            m_infl    = 1;
            m_port    = w;
            m_issue   = c + 1;
        end
        for (int p = 0; p < 2; p++) begin
            if (cap[p]) begin
                m_busy[p] = 1;
                m_pend[p] = 1;
                m_ren[p]  = rr[p];
                m_addr[p] = aa[p];
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge cpu_clk);
            if (cpu_rstn) model_step(cyc);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [BLK-1:0] got, input logic [BLK-1:0] req);
        check_cnt++;
        if (got === req) pass_cnt++;
        else $display("FAIL %s got=%h required=%h", name, got, req);
    endtask

    task automatic check_issue();
        iss_t e;
        if ((exp_iss.size() > 0 && exp_iss[0].cyc <= cyc) || mem_bus.ren != 4'd0) begin
            check_cnt++;
            if (exp_iss.size() == 0) begin
                $display("FAIL mem_issue cyc=%0d got ren=%h addr=%h required no request",
                         cyc, mem_bus.ren, mem_bus.raddr);
            end else begin
                e = exp_iss.pop_front();
                if (e.cyc == cyc && mem_bus.ren === e.ren && mem_bus.raddr === e.addr) begin
                    pass_cnt++;
                    $display("issue   cyc=%0d ren=%h addr=%h", cyc, e.ren, e.addr);
                end else begin
                    $display("FAIL mem_issue cyc=%0d got ren=%h addr=%h required ren=%h addr=%h at cyc %0d",
                             cyc, mem_bus.ren, mem_bus.raddr, e.ren, e.addr, e.cyc);
                end
            end
        end else begin
            check_cnt++;
            if (mem_bus.raddr === 32'd0) pass_cnt++;
            else $display("FAIL mem_idle_addr cyc=%0d got=%h required=0", cyc, mem_bus.raddr);
        end
    endtask

    task automatic check_dlv(input int p);
        logic           v;
        logic [BLK-1:0] d;
        bit             due;
        int             qs;
        dlv_t           e;
        v   = (p == 0) ? ic_bus.rvalid : dc_bus.rvalid;
        d   = (p == 0) ? ic_bus.rdata  : dc_bus.rdata;
        qs  = (p == 0) ? exp_ic.size() : exp_dc.size();
        due = 0;
        if (qs > 0) due = (p == 0) ? (exp_ic[0].cyc <= cyc) : (exp_dc[0].cyc <= cyc);
        if (v === 1'b1 || due) begin
            check_cnt++;
            if (qs == 0) begin
                $display("FAIL deliver%0d cyc=%0d got rvalid=%b required no delivery", p, cyc, v);
            end else begin
                e = (p == 0) ? exp_ic.pop_front() : exp_dc.pop_front();
                if (v === 1'b1 && e.cyc == cyc && d === e.data) begin
                    pass_cnt++;
                    $display("deliver cyc=%0d port=%0d data=%h", cyc, p, d);
                end else begin
                    $display("FAIL deliver%0d cyc=%0d got rvalid=%b data=%h required data=%h at cyc %0d",
                             p, cyc, v, d, e.data, e.cyc);
                end
            end
        end
    endtask

    task automatic check_rrdy();
        check_cnt++;
        if (ic_bus.rrdy === !m_busy[0] && dc_bus.rrdy === !m_busy[1]) pass_cnt++;
        else $display("FAIL rrdy cyc=%0d got ic=%b dc=%b required ic=%b dc=%b",
                      cyc, ic_bus.rrdy, dc_bus.rrdy, !m_busy[0], !m_busy[1]);
    endtask

    initial begin
        forever begin
            @(negedge cpu_clk);
            if (cpu_rstn) begin
                check_issue();
                check_dlv(0);
                check_dlv(1);
                check_rrdy();
            end
        end
    end

    task automatic responder();
        mem_bus.rvalid = 1'b0;
        if (mem_bus.ren != 4'd0 && !r_pend) begin
            r_pend = 1;
            r_dly  = $urandom_range(0, r_dly_max);
        end
        if (r_pend && !r_hold) begin
            if (r_dly == 0) begin
                mem_bus.rvalid = 1'b1;
                mem_bus.rdata  = r_fixed ? {16{8'hA5}} : rand_blk();
                r_pend = 0;
            end else begin
                r_dly--;
            end
        end else if (!r_pend && spur_en && $urandom_range(0, 7) == 0) begin
            mem_bus.rvalid = 1'b1;
            mem_bus.rdata  = rand_blk();
        end
    endtask

    task automatic drive(input logic [3:0] ir, input logic [31:0] ia,
                         input logic [3:0] dr, input logic [31:0] da, input logic rdy);
        @(posedge cpu_clk);
        #1;
        ic_bus.ren   = ir;
        ic_bus.raddr = ia;
        dc_bus.ren   = dr;
        dc_bus.raddr = da;
        mem_bus.rrdy = rdy;
        responder();
    endtask

    function automatic bit model_idle();
        return !m_infl && !m_busy[0] && !m_busy[1]
               && exp_iss.size() == 0 && exp_ic.size() == 0 && exp_dc.size() == 0;
    endfunction

    task automatic drain(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            drive(4'd0, 32'd0, 4'd0, 32'd0, 1'b1);
            @(negedge cpu_clk);
            #1;
            done = model_idle();
        end
        check_cnt++;
        if (done) pass_cnt++;
        else $display("FAIL drain_%s outstanding iss=%0d ic=%0d dc=%0d required all empty",
                      name, exp_iss.size(), exp_ic.size(), exp_dc.size());
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_ren"},   BLK'(mem_bus.ren),   '0);
        chk({tag, "_mem_raddr"}, BLK'(mem_bus.raddr), '0);
        chk({tag, "_ic_rrdy"},   BLK'(ic_bus.rrdy),   BLK'(1));
        chk({tag, "_dc_rrdy"},   BLK'(dc_bus.rrdy),   BLK'(1));
        chk({tag, "_ic_rvalid"}, BLK'(ic_bus.rvalid), '0);
        chk({tag, "_dc_rvalid"}, BLK'(dc_bus.rvalid), '0);
        chk({tag, "_ic_rdata"},  ic_bus.rdata,        '0);
        chk({tag, "_dc_rdata"},  dc_bus.rdata,        '0);
    endtask

    initial begin
        bit          seen;
        logic [3:0]  ir, dr;
        logic [31:0] dc_first;
        ic_bus.ren = '0;  ic_bus.raddr = '0;
        dc_bus.ren = '0;  dc_bus.raddr = '0;
        mem_bus.rrdy = 1'b1;  mem_bus.rvalid = 1'b0;  mem_bus.rdata = '0;
        r_pend = 0; r_hold = 0; r_fixed = 0; spur_en = 0; r_dly = 0; r_dly_max = 0;
        model_reset();

        repeat (3) @(posedge cpu_clk);
        @(negedge cpu_clk);
        #1;
        check_reset_outputs("reset");
        cpu_rstn = 1'b1;

        // single ICache request, response in the first WAIT cycle
        r_fixed = 1;
        drive(4'hF, 32'h1C00_0010, 4'd0, 32'd0, 1'b1);
        drain("single_ic");
        chk("ic_rdata_hold", ic_bus.rdata, {16{8'hA5}});
        chk("dc_rdata_untouched", dc_bus.rdata, '0);
        r_fixed = 0;

        // simultaneous requests, alternation over 4 rounds
        r_dly_max = 2;
        for (int rnd = 0; rnd < 4; rnd++) begin
            if (rnd % 2 == 1) begin
                drive(4'hF, rand_addr(), 4'd0, 32'd0, 1'b1);
                drain("pre_tie");
            end
            drive(4'hF, rand_addr(), 4'hF, rand_addr(), 1'b1);
            drain("tie");
        end

        // mem_rrdy held low with DCache pending
        drive(4'd0, 32'd0, 4'hF, 32'h8000_0100, 1'b0);
        repeat (5) drive(4'd0, 32'd0, 4'd0, 32'd0, 1'b0);
        drain("rrdy_low");

        // second dc_ren while busy is ignored
        dc_first = rand_addr();
        drive(4'd0, 32'd0, 4'hF, dc_first, 1'b1);
        drive(4'd0, 32'd0, 4'h3, dc_first ^ 32'h0000_1000, 1'b1);
        drive(4'd0, 32'd0, 4'hF, dc_first ^ 32'h0000_2000, 1'b1);
        drain("dc_ignore");

        // randomized traffic with spurious responses and back-pressure
        spur_en = 1;
        r_dly_max = 3;
        for (int i = 0; i < 1500; i++) begin
            ir = ($urandom_range(0, 2) == 0) ? rand_ren() : 4'd0;
            dr = ($urandom_range(0, 2) == 0) ? rand_ren() : 4'd0;
            drive(ir, rand_addr(), dr, rand_addr(), ($urandom_range(0, 4) != 0));
        end
        spur_en = 0;
        drain("random");

        // reset while a transaction is in flight
        r_hold = 1;
        drive(4'hF, rand_addr(), 4'hF, rand_addr(), 1'b1);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            drive(4'd0, 32'd0, 4'd0, 32'd0, 1'b1);
            seen = (mem_bus.ren != 4'd0);
        end
        check_cnt++;
        if (seen) pass_cnt++;
        else $display("FAIL wait_issue got no mem_ren within 20 cycles required an issue");
        @(negedge cpu_clk);
        #2;
        cpu_rstn = 1'b0;
        model_reset();
        r_pend = 0;
        r_hold = 0;
        #1;
        check_reset_outputs("midreset");
        ic_bus.ren = '0;
        dc_bus.ren = '0;
        mem_bus.rvalid = 1'b0;
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        #1;
        cpu_rstn = 1'b1;

        // stale response arriving in IDLE is dropped, then a normal request
        drive(4'd0, 32'd0, 4'd0, 32'd0, 1'b1);
        mem_bus.rvalid = 1'b1;
        mem_bus.rdata  = rand_blk();
        drive(4'd0, 32'd0, 4'hF, rand_addr(), 1'b1);
        drain("post_reset");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
